wb_regmap_fifo: RTL and testbench

Parametrised Wishbone B3 slave combining a byte-lane-writable register file with a loop-back FIFO, a status/control window and an interrupt output. It replaces the fixed 16-bit/32-entry register map on the host bridge, adding configurable width and depth, FIFO full/empty protection, bus errors on illegal accesses, and incrementing/constant-address burst support for FIFO streaming.

---
 rtl/wb_regmap_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_wb_regmap_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regmap_fifo.sv
// wb_regmap_fifo
//   Wishbone B3 slave combining a byte-lane writable register file, a
//   loop-back FIFO data port, a read-only status word, a control word
//   and a level interrupt.
//
//   Handshake: an access is wb_cyc_i & wb_stb_i. Each accepted beat is
//   sampled on a rising edge and terminated by wb_ack_o or wb_err_o in the
//   following cycle. Classic / end-of-burst beats hold the termination for
//   one cycle and then force one idle cycle. Burst beats (cti 001/010) keep
//   accepting a new beat every cycle until cti=111, the access drops, or a
//   beat errors. All side effects happen at the edge that registers the
//   termination, once per beat.
//
// Ports
//   wb_clk_i   clock, rising edge
//   wb_rst_i   synchronous active-high reset
//   wb_adr_i   word address (AW)
//   wb_dat_i   write data (DW)
//   wb_dat_o   read data, zero unless a successful read beat is acked
//   wb_sel_i   byte lane enables (DW/8)
//   wb_cti_i   cycle type
//   wb_we_i    write enable
//   wb_stb_i   strobe
//   wb_cyc_i   cycle valid
//   wb_ack_o   normal termination
//   wb_err_o   error termination
//   wb_int_o   registered level interrupt
//   debug_out  {level[11:0], full, empty, err, ack}
module wb_regmap_fifo #(
  parameter int DW       = 16,
  parameter int AW       = 5,
  parameter int NREGS    = 8,
  parameter int FIFO_AW  = 10,
  parameter int FIFO_ADR = 16,
  parameter int STAT_ADR = 17,
  parameter int CTRL_ADR = 18
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [2:0]      wb_cti_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_int_o,
  output logic [15:0]     debug_out
);

  localparam int SW  = DW / 8;
  localparam int SH  = (SW > 1) ? 1 : 0;
  localparam int RIW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int CW  = (FIFO_AW + 1 > 8) ? FIFO_AW + 1 : 8;

  localparam logic [AW-1:0]    A_NREGS = AW'(NREGS);
  localparam logic [AW-1:0]    A_FIFO  = AW'(FIFO_ADR);
  localparam logic [AW-1:0]    A_STAT  = AW'(STAT_ADR);
  localparam logic [AW-1:0]    A_CTRL  = AW'(CTRL_ADR);
  localparam logic [FIFO_AW:0] DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

  // storage
  logic [DW-1:0]      r_regs [NREGS];
  logic [DW-1:0]      r_mem  [2**FIFO_AW];
  logic [DW-1:0]      r_head;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_ovf;
  logic               r_udf;
  logic [2:0]         r_ie;
  logic [7:0]         r_thr;

  // bus termination
  logic               r_ack;
  logic               r_err;
  logic               r_burst;
  logic [DW-1:0]      r_dat;
  logic               r_int;

  // decode
  logic               w_access;
  logic               w_go;
  logic               w_is_reg;
  logic               w_is_fifo;
  logic               w_is_stat;
  logic               w_is_ctrl;
  logic               w_full;
  logic               w_empty;
  logic               w_bad;
  logic               w_ok;
  logic               w_burst_cti;
  logic               w_push;
  logic               w_pop;
  logic               w_reg_wr;
  logic               w_ctrl_wr;
  logic               w_flush;
  logic               w_ovf_set;
  logic               w_udf_set;
  logic               w_sel_hi;
  logic [7:0]         w_ctl_hi;
  logic [RIW-1:0]     w_ridx;
  logic [FIFO_AW-1:0] w_rd_addr;
  logic [DW-1:0]      w_stat;
  logic [DW-1:0]      w_ctrl_rd;
  logic [DW-1:0]      w_rdata;

  always_comb begin
    w_access    = wb_cyc_i & wb_stb_i;
    // A new beat is taken when idle, or every cycle of an acked burst.
    w_go        = w_access & (~(r_ack | r_err) | r_burst);
    w_is_reg    = (wb_adr_i < A_NREGS);
    w_is_fifo   = (wb_adr_i == A_FIFO);
    w_is_stat   = (wb_adr_i == A_STAT);
    w_is_ctrl   = (wb_adr_i == A_CTRL);
    w_full      = (r_level == DEPTH);
    w_empty     = (r_level == '0);
    w_bad       = ~(w_is_reg | w_is_fifo | w_is_stat | w_is_ctrl)
                | (w_is_stat & wb_we_i)
                | (w_is_fifo &  wb_we_i & w_full)
                | (w_is_fifo & ~wb_we_i & w_empty);
    w_ok        = w_go & ~w_bad;
    w_burst_cti = (wb_cti_i == 3'b001) | (wb_cti_i == 3'b010);
    w_push      = w_ok & w_is_fifo &  wb_we_i;
    w_pop       = w_ok & w_is_fifo & ~wb_we_i;
    w_reg_wr    = w_ok & w_is_reg  &  wb_we_i;
    w_ctrl_wr   = w_ok & w_is_ctrl &  wb_we_i;
    w_flush     = w_ctrl_wr & wb_sel_i[0] & wb_dat_i[3];
    w_ovf_set   = w_go & w_is_fifo &  wb_we_i & w_full;
    w_udf_set   = w_go & w_is_fifo & ~wb_we_i & w_empty;
    w_sel_hi    = (SW > 1) ? wb_sel_i[SH] : 1'b0;
    w_ctl_hi    = 8'(wb_dat_i >> 8);
    w_ridx      = wb_adr_i[RIW-1:0];
    // Pre-advancing the read address keeps back-to-back pops bubble-free:
    // r_head always holds the word at the post-edge read pointer.
    w_rd_addr   = r_rd_ptr + FIFO_AW'(w_pop);
    w_stat      = DW'({r_level, r_udf, r_ovf, w_full, w_empty});
    w_ctrl_rd   = DW'({r_thr, 5'b00000, r_ie});
  end

  always_comb begin
    w_rdata = '0;
    if (w_is_reg) begin
      w_rdata = r_regs[w_ridx];
    end else if (w_is_fifo) begin
      w_rdata = r_head;
    end else if (w_is_stat) begin
      w_rdata = w_stat;
    end else if (w_is_ctrl) begin
      w_rdata = w_ctrl_rd;
    end
  end

  // FIFO RAM: synchronous read, no reset on the array.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wb_dat_i;
    end
    r_head <= r_mem[w_rd_addr];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_burst  <= 1'b0;
      r_dat    <= '0;
      r_int    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
      r_ie     <= '0;
      r_thr    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[RIW'(i)] <= '0;
      end
    end else begin
      r_ack   <= w_ok;
      r_err   <= w_go & w_bad;
      r_burst <= w_ok & w_burst_cti;
      r_dat   <= (w_ok & ~wb_we_i) ? w_rdata : '0;

      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_level  <= r_level + 1'b1;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_level  <= r_level - 1'b1;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ctrl_wr & wb_sel_i[0] & wb_dat_i[4]) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end else if (w_ctrl_wr & wb_sel_i[0] & wb_dat_i[5]) begin
        r_udf <= 1'b0;
      end

      if (w_ctrl_wr & wb_sel_i[0]) begin
        r_ie <= wb_dat_i[2:0];
      end
      if (w_ctrl_wr & w_sel_hi) begin
        r_thr <= w_ctl_hi;
      end

      if (w_reg_wr) begin
        for (int b = 0; b < SW; b++) begin
          if (wb_sel_i[b]) begin
            r_regs[w_ridx][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
          end
        end
      end

      r_int <= (r_ie[0] & ~w_empty)
             | (r_ie[1] & (CW'(r_level) >= CW'(r_thr)))
             | (r_ie[2] & (r_ovf | r_udf));
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_dat_o  = r_dat;
  assign wb_int_o  = r_int;
  assign debug_out = {12'(r_level), w_full, w_empty, r_err, r_ack};

endmodule

// File: tb/tb_wb_regmap_fifo.sv
// Directed bench for wb_regmap_fifo, built with a 4-deep FIFO so that the
// full/empty boundaries are reached with short bursts.
module tb_wb_regmap_fifo;

  localparam logic [4:0] A_FIFO = 5'd16;
  localparam logic [4:0] A_STAT = 5'd17;
  localparam logic [4:0] A_CTRL = 5'd18;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [15:0] wdat;
  logic [15:0] dat_o;
  logic [1:0]  sel;
  logic [2:0]  cti;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;
  logic        irq;
  logic [15:0] dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  wb_regmap_fifo #(
    .DW(16), .AW(5), .NREGS(8), .FIFO_AW(2),
    .FIFO_ADR(16), .STAT_ADR(17), .CTRL_ADR(18)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_dat_o (dat_o),
    .wb_sel_i (sel),
    .wb_cti_i (cti),
    .wb_we_i  (we),
    .wb_stb_i (stb),
    .wb_cyc_i (cyc),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_int_o (irq),
    .debug_out(dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    sel = 2'b00; adr = '0; wdat = '0;
  endtask

  logic        t_ack;
  logic        t_err;
  logic [15:0] t_rd;
  int          t_waits;

  task automatic classic(input logic w, input logic [4:0] a, input logic [15:0] d,
                         input logic [1:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; cti = 3'b000;
    t_waits = 0;
    do begin
      tick();
      t_waits++;
    end while (!(ack | err) && t_waits < 8);
    t_ack = ack;
    t_err = err;
    t_rd  = dat_o;
    if (!(t_ack | t_err)) check("classic_timeout", {31'b0, t_ack | t_err}, 32'd1);
    bus_idle();
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
    classic(1'b0, a, 16'h0000, 2'b11);
    check({tag, "_ack"}, {31'b0, t_ack}, 32'd1);
    check(tag, {16'b0, t_rd}, {16'b0, exp});
  endtask

  task automatic wr_ok(input string tag, input logic [4:0] a, input logic [15:0] d,
                       input logic [1:0] s);
    classic(1'b1, a, d, s);
    check({tag, "_ack"}, {31'b0, t_ack}, 32'd1);
  endtask

  logic [15:0] b_wdat[8];
  logic        b_ack[8];
  logic        b_err[8];
  logic [15:0] b_dat[8];

  // One beat per clock to the FIFO port; the last beat carries cti=111.
  task automatic burst(input logic w, input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      cyc = 1'b1; stb = 1'b1; we = w; adr = A_FIFO; sel = 2'b11;
      wdat = b_wdat[i];
      cti = (i == n - 1) ? 3'b111 : c;
      tick();
      b_ack[i] = ack;
      b_err[i] = err;
      b_dat[i] = dat_o;
    end
    bus_idle();
    tick();
  endtask

  initial begin
    bus_idle();
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_int", {31'b0, irq}, 32'd0);
    check("rst_dat", {16'b0, dat_o}, 32'h0);
    check("rst_debug", {16'b0, dbg}, 32'h0004);
    rst = 1'b0;
    tick();

    // register file after reset, one wait state
    for (int i = 0; i < 8; i++) begin
      rd_chk($sformatf("reg%0d_rst", i), 5'(i), 16'h0000);
      if (i == 0) check("wait_states", t_waits, 32'd1);
    end

    // byte lanes
    wr_ok("wr_reg3", 5'd3, 16'hBEEF, 2'b01);
    rd_chk("reg3_lane0", 5'd3, 16'h00EF);
    wr_ok("wr_reg5", 5'd5, 16'hA5C3, 2'b10);
    rd_chk("reg5_lane1", 5'd5, 16'hA500);
    rd_chk("reg3_keep", 5'd3, 16'h00EF);

    // incrementing burst push, constant-address burst pop
    b_wdat[0] = 16'h1111; b_wdat[1] = 16'h2222; b_wdat[2] = 16'h3333; b_wdat[3] = 16'h4444;
    burst(1'b1, 3'b010, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("push_ack%0d", i), {31'b0, b_ack[i]}, 32'd1);
      exp_q.push_back(b_wdat[i]);
    end
    check("debug_full", {16'b0, dbg}, 32'h0048);
    rd_chk("stat_full", A_STAT, 16'h0042);
    burst(1'b0, 3'b001, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop_ack%0d", i), {31'b0, b_ack[i]}, 32'd1);
      check($sformatf("pop_dat%0d", i), {16'b0, b_dat[i]}, {16'b0, exp_q.pop_front()});
    end
    rd_chk("stat_empty", A_STAT, 16'h0001);

    // overflow on the 5th push, underflow on the 5th pop
    for (int i = 0; i < 5; i++) b_wdat[i] = 16'hA000 + 16'(i);
    burst(1'b1, 3'b010, 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_push_ack%0d", i), {31'b0, b_ack[i]}, 32'd1);
      exp_q.push_back(b_wdat[i]);
    end
    check("ovf_beat_err", {31'b0, b_err[4]}, 32'd1);
    check("ovf_beat_noack", {31'b0, b_ack[4]}, 32'd0);
    rd_chk("stat_ovf", A_STAT, 16'h0046);
    for (int i = 0; i < 5; i++) begin
      classic(1'b0, A_FIFO, 16'h0000, 2'b11);
      if (i < 4) begin
        check($sformatf("udf_pop_ack%0d", i), {31'b0, t_ack}, 32'd1);
        check($sformatf("udf_pop_dat%0d", i), {16'b0, t_rd}, {16'b0, exp_q.pop_front()});
      end else begin
        check("udf_beat_err", {31'b0, t_err}, 32'd1);
        check("udf_beat_dat", {16'b0, t_rd}, 32'h0);
      end
    end
    rd_chk("stat_udf", A_STAT, 16'h000D);
    wr_ok("clr_sticky", A_CTRL, 16'h0030, 2'b11);
    rd_chk("stat_cleared", A_STAT, 16'h0001);
    rd_chk("ctrl_self_clear", A_CTRL, 16'h0000);

    // illegal accesses
    classic(1'b0, 5'd31, 16'h0000, 2'b11);
    check("unmapped_err", {31'b0, t_err}, 32'd1);
    check("unmapped_noack", {31'b0, t_ack}, 32'd0);
    check("unmapped_dat", {16'b0, t_rd}, 32'h0);
    check("err_one_cycle", {31'b0, err}, 32'd0);
    classic(1'b1, A_STAT, 16'hFFFF, 2'b11);
    check("stat_wr_err", {31'b0, t_err}, 32'd1);
    rd_chk("stat_unchanged", A_STAT, 16'h0001);

    // threshold interrupt and flush
    wr_ok("ctrl_thr", A_CTRL, 16'h0302, 2'b11);
    rd_chk("ctrl_rb", A_CTRL, 16'h0302);
    check("int_lvl0", {31'b0, irq}, 32'd0);
    wr_ok("thr_push1", A_FIFO, 16'h0B01, 2'b11);
    wr_ok("thr_push2", A_FIFO, 16'h0B02, 2'b11);
    check("int_lvl2", {31'b0, irq}, 32'd0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_FIFO; wdat = 16'h0B03; sel = 2'b11; cti = 3'b000;
    tick();
    check("thr_push3_ack", {31'b0, ack}, 32'd1);
    check("int_at_ack", {31'b0, irq}, 32'd0);
    bus_idle();
    tick();
    check("int_lvl3", {31'b0, irq}, 32'd1);
    rd_chk("stat_lvl3", A_STAT, 16'h0030);
    wr_ok("flush", A_CTRL, 16'h030A, 2'b11);
    check("int_flush", {31'b0, irq}, 32'd0);
    rd_chk("stat_flush", A_STAT, 16'h0001);
    rd_chk("ctrl_after_flush", A_CTRL, 16'h0302);

    // reset during the second beat of a burst
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_FIFO; wdat = 16'hC001; sel = 2'b11; cti = 3'b010;
    tick();
    check("rstb_beat1_ack", {31'b0, ack}, 32'd1);
    wdat = 16'hC002;
    rst = 1'b1;
    tick();
    check("rstb_ack_low", {31'b0, ack}, 32'd0);
    check("rstb_err_low", {31'b0, err}, 32'd0);
    rst = 1'b0;
    bus_idle();
    tick();
    rd_chk("rstb_stat", A_STAT, 16'h0001);
    rd_chk("rstb_ctrl", A_CTRL, 16'h0000);
    rd_chk("rstb_reg3", 5'd3, 16'h0000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
